// File: rtl/hs_ifr_evt_sched_if.sv
// Grant port between the event scheduler and its single consumer.
// The scheduler offers one channel id at a time; the consumer accepts with ready.
interface hs_ifr_evt_sched_if #(
    parameter int N_CH = 4
);
    localparam int ID_W = $clog2(N_CH);

    logic            gnt_valid_o;
    logic [ID_W-1:0] gnt_id_o;
    logic            gnt_ready_i;

    modport master (
        output gnt_valid_o,
        output gnt_id_o,
        input  gnt_ready_i
    );

    modport slave (
        input  gnt_valid_o,
        input  gnt_id_o,
        output gnt_ready_i
    );
endinterface

// File: rtl/hs_ifr_evt_sched.sv
// Per-channel event trigger detection with a round-robin grant scheduler.
// Edge-mode channels latch a sticky pending bit; level-mode channels track
// their condition every cycle. Pending channels are offered one at a time.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no grant offered; pick next pending channel after last_id
// ST_OFFER | gnt_valid_o held with a stable id until the consumer accepts
module hs_ifr_evt_sched #(
    parameter int N_CH = 4,
    localparam int ID_W = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      evt_i,
    input  logic [N_CH-1:0]      cfg_en_i,
    input  logic [N_CH-1:0]      cfg_lvl_i,
    input  logic [2*N_CH-1:0]    cfg_sel_i,
    input  logic [N_CH-1:0]      ovf_clr_i,
    hs_ifr_evt_sched_if.master   gnt,
    output logic [N_CH-1:0]      pend_o,
    output logic [N_CH-1:0]      ovf_o
);

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2,
        EDGE_NONE = 2'd3
    } edge_e;

    typedef enum logic [1:0] {
        LVL_LOW    = 2'd0,
        LVL_HIGH   = 2'd1,
        LVL_ALWAYS = 2'd2,
        LVL_NONE   = 2'd3
    } level_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N_CH-1:0] evt_q;
    logic [N_CH-1:0] rise, fall, hit;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] ovf_q, ovf_d;
    logic [N_CH-1:0] hs_sel, offer_sel;
    logic            gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [ID_W-1:0] last_id_q, last_id_d;
    logic            handshake;
    logic            pick_found;
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] scan_id;

    assign rise      = evt_i & ~evt_q;
    assign fall      = ~evt_i & evt_q;
    assign handshake = gnt_valid_q & gnt.gnt_ready_i;

    assign gnt.gnt_valid_o = gnt_valid_q;
    assign gnt.gnt_id_o    = gnt_id_q;
    assign pend_o          = pend_q;
    assign ovf_o           = ovf_q;

    // Decode the per-channel trigger condition for the selected mode, gated by enable.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_lvl_i[i]) begin
                case (level_e'(cfg_sel_i[2*i +: 2]))
                    LVL_LOW:    hit[i] = ~evt_i[i];
                    LVL_HIGH:   hit[i] = evt_i[i];
                    LVL_ALWAYS: hit[i] = 1'b1;
                    default:    hit[i] = 1'b0;
                endcase
            end else begin
                case (edge_e'(cfg_sel_i[2*i +: 2]))
                    EDGE_RISE: hit[i] = rise[i];
                    EDGE_FALL: hit[i] = fall[i];
                    EDGE_ANY:  hit[i] = rise[i] | fall[i];
                    default:   hit[i] = 1'b0;
                endcase
            end
            hit[i] = hit[i] & cfg_en_i[i];
        end
    end

    // One-hot views of which channel is currently offered and which is being accepted.
    always_comb begin
        hs_sel    = '0;
        offer_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            offer_sel[i] = gnt_valid_q && (gnt_id_q == ID_W'(i));
            hs_sel[i]    = handshake && (gnt_id_q == ID_W'(i));
        end
    end

    // Pending and overflow update. A new hit coinciding with acceptance keeps
    // the channel pending without counting as a lost event.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q & ~ovf_clr_i;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_lvl_i[i]) begin
                pend_d[i] = hit[i];
            end else if (!cfg_en_i[i] && !offer_sel[i]) begin
                pend_d[i] = 1'b0;
            end else if (hit[i]) begin
                pend_d[i] = 1'b1;
            end else if (hs_sel[i]) begin
                pend_d[i] = 1'b0;
            end
            if (!cfg_lvl_i[i] && hit[i] && pend_q[i] && !hs_sel[i]) begin
                ovf_d[i] = 1'b1;
            end
        end
    end

    // Round-robin search: first pending channel strictly after last_id, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_id    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            scan_id = ID_W'((int'(last_id_q) + k) % N_CH);
            if (!pick_found && pend_q[scan_id]) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    // Grant FSM next-state and registered grant outputs.
    always_comb begin
        state_d     = state_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        last_id_d   = last_id_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_id_d    = pick_id;
                    gnt_valid_d = 1'b1;
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (handshake) begin
                    last_id_d   = gnt_id_q;
                    gnt_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                gnt_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            evt_q       <= '0;
            pend_q      <= '0;
            ovf_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            last_id_q   <= ID_W'(N_CH - 1);
        end else begin
            state_q     <= state_d;
            evt_q       <= evt_i;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            last_id_q   <= last_id_d;
        end
    end

endmodule

// File: tb/tb_hs_ifr_evt_sched.sv
// Directed bench for hs_ifr_evt_sched with N_CH = 4.
module tb_hs_ifr_evt_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] evt_i;
    logic [3:0] cfg_en_i;
    logic [3:0] cfg_lvl_i;
    logic [7:0] cfg_sel_i;
    logic [3:0] ovf_clr_i;
    logic [3:0] pend_o;
    logic [3:0] ovf_o;

    int total = 0;
    int bad   = 0;

    hs_ifr_evt_sched_if #(.N_CH(4)) gnt_if ();

    hs_ifr_evt_sched #(.N_CH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt_i     (evt_i),
        .cfg_en_i  (cfg_en_i),
        .cfg_lvl_i (cfg_lvl_i),
        .cfg_sel_i (cfg_sel_i),
        .ovf_clr_i (ovf_clr_i),
        .gnt       (gnt_if),
        .pend_o    (pend_o),
        .ovf_o     (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        evt_i = '0; cfg_en_i = '0; cfg_lvl_i = '0; cfg_sel_i = '0; ovf_clr_i = '0;
        gnt_if.gnt_ready_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (gnt_if.gnt_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", gnt_if.gnt_valid_o); end
        total++; if (gnt_if.gnt_id_o !== 2'd0) begin bad++; $display("FAIL rst_id got=%0d exp=0", gnt_if.gnt_id_o); end
        total++; if (pend_o !== 4'h0) begin bad++; $display("FAIL rst_pend got=%0h exp=0", pend_o); end
        total++; if (ovf_o !== 4'h0) begin bad++; $display("FAIL rst_ovf got=%0h exp=0", ovf_o); end
    endtask

    task automatic test_latency();
        do_reset();
        cfg_en_i = 4'b0001;
        evt_i = 4'b0001;
        step();
        total++; if (pend_o !== 4'b0001) begin bad++; $display("FAIL lat_pend got=%0h exp=1", pend_o); end
        total++; if (gnt_if.gnt_valid_o !== 1'b0) begin bad++; $display("FAIL lat_valid_early got=%0b exp=0", gnt_if.gnt_valid_o); end
        step();
        total++; if (gnt_if.gnt_valid_o !== 1'b1 || gnt_if.gnt_id_o !== 2'd0) begin bad++; $display("FAIL lat_grant got=%0b/%0d exp=1/0", gnt_if.gnt_valid_o, gnt_if.gnt_id_o); end
        gnt_if.gnt_ready_i = 1'b1;
        step();
        total++; if (gnt_if.gnt_valid_o !== 1'b0 || pend_o !== 4'h0) begin bad++; $display("FAIL lat_accept got=%0b/%0h exp=0/0", gnt_if.gnt_valid_o, pend_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cfg_en_i  = 4'b1111;
        cfg_sel_i = 8'b10_10_10_10;
        gnt_if.gnt_ready_i = 1'b1;
        evt_i = 4'b1111;
        step();
        total++; if (pend_o !== 4'b1111) begin bad++; $display("FAIL b2b_pend got=%0h exp=f", pend_o); end
        for (int g = 0; g < 4; g++) begin
            step();
            total++; if (gnt_if.gnt_valid_o !== 1'b1 || gnt_if.gnt_id_o !== 2'(g)) begin bad++; $display("FAIL b2b_grant got=%0b/%0d exp=1/%0d", gnt_if.gnt_valid_o, gnt_if.gnt_id_o, g); end
            step();
            total++; if (gnt_if.gnt_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%0b exp=0", gnt_if.gnt_valid_o); end
        end
        total++; if (pend_o !== 4'h0) begin bad++; $display("FAIL b2b_end_pend got=%0h exp=0", pend_o); end
        gnt_if.gnt_ready_i = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        cfg_en_i = 4'b0010;
        evt_i = 4'b0010;
        step();
        step();
        total++; if (gnt_if.gnt_valid_o !== 1'b1 || gnt_if.gnt_id_o !== 2'd1) begin bad++; $display("FAIL ovf_grant got=%0b/%0d exp=1/1", gnt_if.gnt_valid_o, gnt_if.gnt_id_o); end
        evt_i = 4'b0000;
        step();
        total++; if (ovf_o !== 4'h0) begin bad++; $display("FAIL ovf_fall got=%0h exp=0", ovf_o); end
        evt_i = 4'b0010;
        step();
        total++; if (ovf_o !== 4'b0010) begin bad++; $display("FAIL ovf_set got=%0h exp=2", ovf_o); end
        ovf_clr_i = 4'b0010;
        step();
        ovf_clr_i = 4'b0000;
        total++; if (ovf_o !== 4'h0) begin bad++; $display("FAIL ovf_clr got=%0h exp=0", ovf_o); end
        evt_i = 4'b0000;
        step();
        evt_i = 4'b0010;
        gnt_if.gnt_ready_i = 1'b1;
        step();
        gnt_if.gnt_ready_i = 1'b0;
        total++; if (gnt_if.gnt_valid_o !== 1'b0 || pend_o !== 4'b0010 || ovf_o !== 4'h0) begin bad++; $display("FAIL ovf_hs_hit got=%0b/%0h/%0h exp=0/2/0", gnt_if.gnt_valid_o, pend_o, ovf_o); end
        step();
        total++; if (gnt_if.gnt_valid_o !== 1'b1 || gnt_if.gnt_id_o !== 2'd1) begin bad++; $display("FAIL ovf_reoffer got=%0b/%0d exp=1/1", gnt_if.gnt_valid_o, gnt_if.gnt_id_o); end
        evt_i = 4'b0000;
        step();
        evt_i = 4'b0010;
        ovf_clr_i = 4'b0010;
        step();
        ovf_clr_i = 4'b0000;
        total++; if (ovf_o !== 4'b0010) begin bad++; $display("FAIL ovf_set_wins got=%0h exp=2", ovf_o); end
    endtask

    task automatic test_level();
        do_reset();
        cfg_en_i  = 4'b0100;
        cfg_lvl_i = 4'b0100;
        cfg_sel_i = 8'b00_01_00_00;
        evt_i = 4'b0100;
        step();
        total++; if (pend_o !== 4'b0100) begin bad++; $display("FAIL lvl_pend got=%0h exp=4", pend_o); end
        for (int c = 0; c < 5; c++) begin
            step();
            total++; if (gnt_if.gnt_valid_o !== 1'b1 || gnt_if.gnt_id_o !== 2'd2) begin bad++; $display("FAIL lvl_hold got=%0b/%0d exp=1/2", gnt_if.gnt_valid_o, gnt_if.gnt_id_o); end
        end
        evt_i = 4'b0000;
        step();
        total++; if (pend_o !== 4'h0 || gnt_if.gnt_valid_o !== 1'b1 || gnt_if.gnt_id_o !== 2'd2) begin bad++; $display("FAIL lvl_drop got=%0h/%0b/%0d exp=0/1/2", pend_o, gnt_if.gnt_valid_o, gnt_if.gnt_id_o); end
        gnt_if.gnt_ready_i = 1'b1;
        step();
        gnt_if.gnt_ready_i = 1'b0;
        total++; if (gnt_if.gnt_valid_o !== 1'b0 || pend_o !== 4'h0) begin bad++; $display("FAIL lvl_accept got=%0b/%0h exp=0/0", gnt_if.gnt_valid_o, pend_o); end
        step();
        total++; if (gnt_if.gnt_valid_o !== 1'b0) begin bad++; $display("FAIL lvl_idle got=%0b exp=0", gnt_if.gnt_valid_o); end
    endtask

    task automatic test_rotation();
        do_reset();
        cfg_en_i = 4'b1111;
        evt_i = 4'b0010;
        step();
        step();
        gnt_if.gnt_ready_i = 1'b1;
        step();
        gnt_if.gnt_ready_i = 1'b0;
        evt_i = 4'b0111;
        step();
        total++; if (pend_o !== 4'b0101) begin bad++; $display("FAIL rot_pend got=%0h exp=5", pend_o); end
        step();
        total++; if (gnt_if.gnt_valid_o !== 1'b1 || gnt_if.gnt_id_o !== 2'd2) begin bad++; $display("FAIL rot_first got=%0b/%0d exp=1/2", gnt_if.gnt_valid_o, gnt_if.gnt_id_o); end
        gnt_if.gnt_ready_i = 1'b1;
        step();
        step();
        total++; if (gnt_if.gnt_valid_o !== 1'b1 || gnt_if.gnt_id_o !== 2'd0) begin bad++; $display("FAIL rot_second got=%0b/%0d exp=1/0", gnt_if.gnt_valid_o, gnt_if.gnt_id_o); end
        step();
        gnt_if.gnt_ready_i = 1'b0;
        total++; if (pend_o !== 4'h0) begin bad++; $display("FAIL rot_end_pend got=%0h exp=0", pend_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        cfg_en_i = 4'b1001;
        evt_i = 4'b1000;
        step();
        step();
        total++; if (gnt_if.gnt_valid_o !== 1'b1 || gnt_if.gnt_id_o !== 2'd3) begin bad++; $display("FAIL wrap_ch3 got=%0b/%0d exp=1/3", gnt_if.gnt_valid_o, gnt_if.gnt_id_o); end
        gnt_if.gnt_ready_i = 1'b1;
        evt_i = 4'b0000;
        step();
        gnt_if.gnt_ready_i = 1'b0;
        evt_i = 4'b1001;
        step();
        total++; if (pend_o !== 4'b1001) begin bad++; $display("FAIL wrap_pend got=%0h exp=9", pend_o); end
        step();
        total++; if (gnt_if.gnt_valid_o !== 1'b1 || gnt_if.gnt_id_o !== 2'd0) begin bad++; $display("FAIL wrap_ch0 got=%0b/%0d exp=1/0", gnt_if.gnt_valid_o, gnt_if.gnt_id_o); end
        gnt_if.gnt_ready_i = 1'b1;
        step();
        step();
        total++; if (gnt_if.gnt_valid_o !== 1'b1 || gnt_if.gnt_id_o !== 2'd3) begin bad++; $display("FAIL wrap_then3 got=%0b/%0d exp=1/3", gnt_if.gnt_valid_o, gnt_if.gnt_id_o); end
        step();
        gnt_if.gnt_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        cfg_en_i = 4'b0011;
        evt_i = 4'b0010;
        step();
        step();
        total++; if (gnt_if.gnt_valid_o !== 1'b1 || gnt_if.gnt_id_o !== 2'd1) begin bad++; $display("FAIL arst_pre got=%0b/%0d exp=1/1", gnt_if.gnt_valid_o, gnt_if.gnt_id_o); end
        rst_n = 1'b0;
        evt_i = 4'b0000;
        #1;
        total++; if (gnt_if.gnt_valid_o !== 1'b0 || pend_o !== 4'h0) begin bad++; $display("FAIL arst_drop got=%0b/%0h exp=0/0", gnt_if.gnt_valid_o, pend_o); end
        step();
        rst_n = 1'b1;
        evt_i = 4'b0011;
        step();
        total++; if (pend_o !== 4'b0011) begin bad++; $display("FAIL arst_pend got=%0h exp=3", pend_o); end
        step();
        total++; if (gnt_if.gnt_valid_o !== 1'b1 || gnt_if.gnt_id_o !== 2'd0) begin bad++; $display("FAIL arst_prio got=%0b/%0d exp=1/0", gnt_if.gnt_valid_o, gnt_if.gnt_id_o); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_overflow();
        test_level();
        test_rotation();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
